sha2_xl_axil_slave: RTL and testbench
=====================================

# sha2_xl_axil_slave

AXI4-Lite slave register interface of the SHA-2 XL IP (the S00_AXI port). It terminates reads and writes from the system AXI4-Lite master (the VIP master on the verification side). It maps them onto control, address and 64-bit data registers that drive the SHA-2 core. It also returns core status and digest words to the master.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; 16 word slots.
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID / S_AXI_AWREADY  in/in/in/out  6/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID / S_AXI_ARREADY  in/in/in/out  6/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  32/2/1/1  read data channel.
- ctrl_o  out  32  CTRL register contents: bit0 start, bit1 core soft reset, bits[3:2] mode (224/256/384/512).
- addr_o  out  32  ADDR register, the core word index.
- din_o  out  64  {DIN_HI, DIN_LO}.
- ctrl_wr_o  out  1  one-cycle pulse when CTRL is written.
- din_wr_o  out  1  one-cycle pulse when DIN_HI is written.
- status_i  in  32  core status (bit0 busy, bit1 done).
- dout_i  in  64  core output word selected by addr_o.

## Operation
- Register map (byte offset):
  - 0x00 CTRL, RW.
  - 0x04 ADDR, RW.
  - 0x08 DIN_LO, RW.
  - 0x0C DIN_HI, RW.
  - 0x10 STATUS, RO, returns status_i.
  - 0x14 DOUT_LO, RO, returns dout_i[31:0].
  - 0x18 DOUT_HI, RO, returns dout_i[63:32].
  - 0x1C–0x3C unmapped.
- RW registers read back exactly what was written; none are self-clearing. Side effects happen only through the pulses.
- WSTRB applies per byte to RW registers. A byte with strobe 0 keeps its old value. A pulse still fires when WSTRB=0.
- Writes to RO or unmapped offsets are discarded. Reads of unmapped offsets return 0.
- BRESP and RRESP are always OKAY (2'b00).
- Address decode uses bits [5:2]; bits [1:0] are ignored.
- Write path:
  - AW and W are captured independently into holding registers, in either order and with any gap between them.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - Commit happens at the first edge where both are held and BVALID=0. At that edge: the register is updated, BVALID is set, both held flags clear, and the pulse for the target register is raised.
  - BVALID stays high until the BREADY handshake.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake, RDATA and RVALID are registered at the next edge. RDATA is held stable until the RREADY handshake.
- Simultaneous write commit and read of the same register on the same edge: the read returns the pre-write value.

## Timing
- Reset values: all registers, RDATA, BVALID, RVALID, pulses and held flags are 0.
- READY outputs are 0 while ARESETN is low. They become active from the first rising ACLK edge with ARESETN high.
- Write latency: AW and W both accepted at edge E → BVALID high after edge E+1; pulse high for exactly the cycle after E+1.
- W accepted at edge E, AW accepted at edge E+k → commit at E+k+1.
- Read latency: AR accepted at edge E → RVALID after E+1, with status/dout sampled at E+1. Next ARREADY comes one cycle after the R handshake.
- Outstanding transactions: at most one write and one read. The read and write paths are fully independent.
- Reset asserted mid-transaction: any in-flight AW, W or AR is dropped, all outputs return to reset values immediately, and no BVALID or RVALID follows.

## Structure
- Package sha2_xl_pkg holds:
  - register offset localparams (CTRL..DOUT_HI);
  - AXI_RESP_OKAY;
  - the mode enum (SHA224/256/384/512);
  - CTRL bit positions.
- Single module. The read mux and the write decode are inline, with no sub-module.
- Target size ~200 lines.

## Test plan
- Reset: hold ARESETN low for 200 ns → all outputs 0. After release, AWREADY/WREADY/ARREADY = 1 from the first clock edge.
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C with WSTRB=0xF, then read back → 0x1, 0x2, 0x3, 0x4 with BRESP = RRESP = 0. Each write pulses ctrl_wr_o or din_wr_o on the offsets that have a pulse.
- W (0xDEADBEEF to 0x04) three cycles ahead of AW → exactly one BVALID, after the AW edge plus 1. ADDR reads 0xDEADBEEF.
- DIN_LO = 0x00000003, then write 0xAABBCCDD with WSTRB=0b0010 → reads 0x0000CC03. Writing 0x12345678 to 0x0C → din_wr_o high for 1 cycle with din_o = 0x1234567800000003.
- Hold BREADY low for 5 cycles → BVALID stays high and AWREADY/WREADY stay low, so a second write stalls. It completes once BREADY rises.
- status_i = 0x2, dout_i = 0x0123456789ABCDEF; read 0x10/0x14/0x18/0x20 → 0x2 / 0x89ABCDEF / 0x01234567 / 0x0. Pulse ARESETN low during a pending read → RVALID drops and does not reassert.

Source files
------------

// File: rtl/sha2_xl_axil_slave_pkg.sv
// Shared definitions for the SHA-2 XL AXI4-Lite register slave.
// Holds the register map offsets, the AXI response code, the digest mode
// encoding, CTRL bit positions and a byte-strobe merge helper.
package sha2_xl_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 6;

  // Register map, byte offsets.
  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_ADDR    = 6'h04;
  localparam logic [5:0] OFF_DIN_LO  = 6'h08;
  localparam logic [5:0] OFF_DIN_HI  = 6'h0C;
  localparam logic [5:0] OFF_STATUS  = 6'h10;
  localparam logic [5:0] OFF_DOUT_LO = 6'h14;
  localparam logic [5:0] OFF_DOUT_HI = 6'h18;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    MODE_SHA224 = 2'd0,
    MODE_SHA256 = 2'd1,
    MODE_SHA384 = 2'd2,
    MODE_SHA512 = 2'd3
  } sha2_mode_e;

  // CTRL field positions.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_SRST_BIT  = 1;
  localparam int CTRL_MODE_LSB  = 2;
  localparam int CTRL_MODE_MSB  = 3;

  // Merge a write into an existing register; bytes with strobe 0 keep old data.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sha2_xl_axil_slave_if.sv
// AXI4-Lite bus bundle between the system master and the SHA-2 XL slave.
// Ports: AW/W/B write channels and AR/R read channels, valid/ready paired.
// Modports: master drives requests and response-readies, slave the reverse.
interface sha2_xl_axil_slave_if
  import sha2_xl_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sha2_xl_axil_slave.sv
// AXI4-Lite slave mapping CTRL/ADDR/DIN registers to the SHA-2 core and
// returning STATUS/DOUT. Write: AW+W accepted at E -> BVALID and pulse after
// E+1. Read: AR at E -> RVALID after E+1. One write and one read outstanding;
// a held BVALID/RVALID blocks its own channel's READY signals.
// Ports: ACLK/ARESETN, s_axi bus, ctrl_o/addr_o/din_o register outputs,
// ctrl_wr_o/din_wr_o write pulses, status_i/dout_i core readback.
module sha2_xl_axil_slave
  import sha2_xl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = AXI_ADDR_W
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  sha2_xl_axil_slave_if.slave        s_axi,
  output logic [31:0]                ctrl_o,
  output logic [31:0]                addr_o,
  output logic [63:0]                din_o,
  output logic                       ctrl_wr_o,
  output logic                       din_wr_o,
  input  logic [31:0]                status_i,
  input  logic [63:0]                dout_i
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(OFF_CTRL    >> 2);
  localparam logic [IDX_W-1:0] IDX_ADDR    = IDX_W'(OFF_ADDR    >> 2);
  localparam logic [IDX_W-1:0] IDX_DIN_LO  = IDX_W'(OFF_DIN_LO  >> 2);
  localparam logic [IDX_W-1:0] IDX_DIN_HI  = IDX_W'(OFF_DIN_HI  >> 2);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(OFF_STATUS  >> 2);
  localparam logic [IDX_W-1:0] IDX_DOUT_LO = IDX_W'(OFF_DOUT_LO >> 2);
  localparam logic [IDX_W-1:0] IDX_DOUT_HI = IDX_W'(OFF_DOUT_HI >> 2);

  // Readies stay low until the first clock edge after reset release.
  logic ready_en_q;

  logic                          aw_held_q, aw_held_d;
  logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
  logic                          w_held_q, w_held_d;
  logic [31:0]                   w_data_q, w_data_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d;
  logic [31:0]                   ctrl_q, ctrl_d;
  logic [31:0]                   addr_q, addr_d;
  logic [31:0]                   din_lo_q, din_lo_d;
  logic [31:0]                   din_hi_q, din_hi_d;
  logic                          ctrl_wr_q, ctrl_wr_d;
  logic                          din_wr_q, din_wr_d;
  logic                          rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]              ar_idx_q, ar_idx_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]                   rd_mux;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs, commit;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign aw_rdy = ready_en_q && !aw_held_q && !bvalid_q;
  assign w_rdy  = ready_en_q && !w_held_q  && !bvalid_q;
  // rd_pend_q covers the cycle between AR acceptance and RVALID.
  assign ar_rdy = ready_en_q && !rd_pend_q && !rvalid_q;

  assign aw_hs  = s_axi.awvalid && aw_rdy;
  assign w_hs   = s_axi.wvalid  && w_rdy;
  assign ar_hs  = s_axi.arvalid && ar_rdy;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  // Read data mux; RO core inputs are sampled on the edge that raises RVALID.
  always_comb begin
    rd_mux = '0;
    case (ar_idx_q)
      IDX_CTRL:    rd_mux = ctrl_q;
      IDX_ADDR:    rd_mux = addr_q;
      IDX_DIN_LO:  rd_mux = din_lo_q;
      IDX_DIN_HI:  rd_mux = din_hi_q;
      IDX_STATUS:  rd_mux = status_i;
      IDX_DOUT_LO: rd_mux = dout_i[31:0];
      IDX_DOUT_HI: rd_mux = dout_i[63:32];
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    din_lo_d  = din_lo_q;
    din_hi_d  = din_hi_q;
    ctrl_wr_d = 1'b0;
    din_wr_d  = 1'b0;
    rd_pend_d = rd_pend_q;
    ar_idx_d  = ar_idx_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.wdata;
      w_strb_d = s_axi.wstrb;
    end

    // commit needs !bvalid_q, so it never overlaps a B handshake.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (aw_idx_q)
        IDX_CTRL: begin
          ctrl_d    = apply_wstrb(ctrl_q, w_data_q, w_strb_q);
          ctrl_wr_d = 1'b1;
        end
        IDX_ADDR:   addr_d   = apply_wstrb(addr_q, w_data_q, w_strb_q);
        IDX_DIN_LO: din_lo_d = apply_wstrb(din_lo_q, w_data_q, w_strb_q);
        IDX_DIN_HI: begin
          din_hi_d = apply_wstrb(din_hi_q, w_data_q, w_strb_q);
          din_wr_d = 1'b1;
        end
        default: ;
      endcase
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    if (rd_pend_q) begin
      rd_pend_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_mux;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rd_pend_d = 1'b1;
      ar_idx_d  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      ctrl_q     <= '0;
      addr_q     <= '0;
      din_lo_q   <= '0;
      din_hi_q   <= '0;
      ctrl_wr_q  <= 1'b0;
      din_wr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      ar_idx_q   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      din_lo_q   <= din_lo_d;
      din_hi_q   <= din_hi_d;
      ctrl_wr_q  <= ctrl_wr_d;
      din_wr_q   <= din_wr_d;
      rd_pend_q  <= rd_pend_d;
      ar_idx_q   <= ar_idx_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = AXI_RESP_OKAY;

  assign ctrl_o    = ctrl_q;
  assign addr_o    = addr_q;
  assign din_o     = {din_hi_q, din_lo_q};
  assign ctrl_wr_o = ctrl_wr_q;
  assign din_wr_o  = din_wr_q;

endmodule

// File: tb/tb_sha2_xl_axil_slave.sv
// Directed bench for the SHA-2 XL AXI4-Lite slave: reset, register access,
// strobes, channel ordering, backpressure, read mux and reset during a read.
module tb_sha2_xl_axil_slave;
  import sha2_xl_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] ctrl_o, addr_o, status_i;
  logic [63:0] din_o, dout_i;
  logic        ctrl_wr_o, din_wr_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  sha2_xl_axil_slave_if bus ();

  sha2_xl_axil_slave dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .s_axi     (bus),
    .ctrl_o    (ctrl_o),
    .addr_o    (addr_o),
    .din_o     (din_o),
    .ctrl_wr_o (ctrl_wr_o),
    .din_wr_o  (din_wr_o),
    .status_i  (status_i),
    .dout_i    (dout_i)
  );

  task automatic bus_idle();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // Full write with AW and W presented together; reports pulses seen.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output int ctrl_pulses, output int din_pulses,
                           output logic [63:0] din_at_pulse);
    logic aw_go, w_go, b_go, done;
    resp = 2'bxx; ctrl_pulses = 0; din_pulses = 0; din_at_pulse = 'x; done = 1'b0;
    @(negedge ACLK);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      b_go  = bus.bvalid && bus.bready;
      if (ctrl_wr_o) ctrl_pulses++;
      if (din_wr_o) begin din_pulses++; din_at_pulse = din_o; end
      if (b_go) resp = bus.bresp;
      @(negedge ACLK);
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go) bus.wvalid = 1'b0;
      if (b_go) done = 1'b1;
    end
    bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("FAIL write_timeout addr=%h got no B response", a); end
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ar_go, r_go, done;
    data = 'x; resp = 2'bxx; done = 1'b0;
    @(negedge ACLK);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      ar_go = bus.arvalid && bus.arready;
      r_go  = bus.rvalid && bus.rready;
      if (r_go) begin data = bus.rdata; resp = bus.rresp; end
      @(negedge ACLK);
      if (ar_go) bus.arvalid = 1'b0;
      if (r_go) done = 1'b1;
    end
    bus.rready = 1'b0; bus.arvalid = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("FAIL read_timeout addr=%h got no R response", a); end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    bus_idle();
    status_i = '0; dout_i = '0;
    #200;
    vectors++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ready got %b want 000", {bus.awready, bus.wready, bus.arready});
    end
    vectors++;
    if ({bus.bvalid, bus.rvalid, ctrl_wr_o, din_wr_o} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_valids got %b want 0000", {bus.bvalid, bus.rvalid, ctrl_wr_o, din_wr_o});
    end
    vectors++;
    if ({ctrl_o, addr_o, din_o, bus.rdata} !== 160'h0) begin
      miscompares++; $display("FAIL reset_regs got %h want 0", {ctrl_o, addr_o, din_o, bus.rdata});
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    vectors++;
    if (bus.awready !== 1'b0) begin
      miscompares++; $display("FAIL ready_before_edge got %b want 0", bus.awready);
    end
    @(posedge ACLK);
    #1;
    vectors++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      miscompares++; $display("FAIL ready_after_edge got %b want 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_reg_rw();
    logic [5:0]  offs [4] = '{6'h00, 6'h04, 6'h08, 6'h0C};
    logic [31:0] vals [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    int          cexp [4] = '{1, 0, 0, 0};
    int          dexp [4] = '{0, 0, 0, 1};
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [63:0] dp;
    int cp, dpn;
    for (int i = 0; i < 4; i++) begin
      axi_write(offs[i], vals[i], 4'hF, resp, cp, dpn, dp);
      vectors++;
      if (resp !== 2'b00 || cp != cexp[i] || dpn != dexp[i]) begin
        miscompares++;
        $display("FAIL wr_%h bresp/ctrl_wr/din_wr got %b/%0d/%0d want 00/%0d/%0d", offs[i], resp, cp, dpn, cexp[i], dexp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(offs[i], rd, resp);
      vectors++;
      if (rd !== vals[i] || resp !== 2'b00) begin
        miscompares++; $display("FAIL rd_%h got %h/%b want %h/00", offs[i], rd, resp, vals[i]);
      end
    end
    vectors++;
    if (ctrl_o !== 32'h1 || addr_o !== 32'h2 || din_o !== 64'h00000004_00000003) begin
      miscompares++; $display("FAIL reg_outputs got %h %h %h", ctrl_o, addr_o, din_o);
    end
    // Mode field lands where the core expects it.
    axi_write(OFF_CTRL, 32'h0000000D, 4'hF, resp, cp, dpn, dp);
    vectors++;
    if (ctrl_o[CTRL_MODE_MSB:CTRL_MODE_LSB] !== MODE_SHA512 || ctrl_o[CTRL_START_BIT] !== 1'b1 || ctrl_o[CTRL_SRST_BIT] !== 1'b0) begin
      miscompares++; $display("FAIL ctrl_fields got %h want 0000000d", ctrl_o);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd;
    logic [1:0]  resp;
    int nb = 0;
    bus.bready = 1'b1;
    @(negedge ACLK);
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    vectors++;
    if (bus.wready !== 1'b1) begin miscompares++; $display("FAIL wready_idle got %b want 1", bus.wready); end
    @(negedge ACLK); bus.wvalid = 1'b0; nb += int'(bus.bvalid);
    @(negedge ACLK); nb += int'(bus.bvalid);
    @(negedge ACLK); nb += int'(bus.bvalid);
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    @(negedge ACLK); bus.awvalid = 1'b0;
    vectors++;
    if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL bvalid_at_aw_edge got %b want 0", bus.bvalid); end
    nb += int'(bus.bvalid);
    @(negedge ACLK);
    vectors++;
    if (bus.bvalid !== 1'b1) begin miscompares++; $display("FAIL bvalid_aw_plus1 got %b want 1", bus.bvalid); end
    nb += int'(bus.bvalid);
    for (int i = 0; i < 6; i++) begin @(negedge ACLK); nb += int'(bus.bvalid); end
    bus.bready = 1'b0;
    vectors++;
    if (nb != 1) begin miscompares++; $display("FAIL bvalid_count got %0d want 1", nb); end
    axi_read(6'h04, rd, resp);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL addr_after_w_first got %h want deadbeef", rd); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [63:0] dp;
    logic [31:0] c0, a0;
    logic [63:0] d0;
    int cp, dpn;
    axi_write(6'h08, 32'h00000003, 4'hF, resp, cp, dpn, dp);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0010, resp, cp, dpn, dp);
    axi_read(6'h08, rd, resp);
    vectors++;
    if (rd !== 32'h0000CC03) begin miscompares++; $display("FAIL strobe_merge got %h want 0000cc03", rd); end
    axi_write(6'h08, 32'h00000003, 4'hF, resp, cp, dpn, dp);
    axi_write(6'h0C, 32'h12345678, 4'hF, resp, cp, dpn, dp);
    vectors++;
    if (dpn != 1 || dp !== 64'h12345678_00000003) begin
      miscompares++; $display("FAIL din_pulse got %0d/%h want 1/1234567800000003", dpn, dp);
    end
    // Zero strobe: data kept, pulse still fires.
    c0 = ctrl_o;
    axi_write(6'h00, 32'hFFFFFFFF, 4'h0, resp, cp, dpn, dp);
    vectors++;
    if (cp != 1 || ctrl_o !== c0) begin
      miscompares++; $display("FAIL zero_strobe got %0d/%h want 1/%h", cp, ctrl_o, c0);
    end
    // RO and unmapped writes change nothing.
    c0 = ctrl_o; a0 = addr_o; d0 = din_o;
    axi_write(6'h10, 32'hFFFFFFFF, 4'hF, resp, cp, dpn, dp);
    axi_write(6'h24, 32'hFFFFFFFF, 4'hF, resp, cp, dpn, dp);
    vectors++;
    if (ctrl_o !== c0 || addr_o !== a0 || din_o !== d0 || cp != 0 || dpn != 0 || resp !== 2'b00) begin
      miscompares++; $display("FAIL ro_write got %h %h %h %0d %0d", ctrl_o, addr_o, din_o, cp, dpn);
    end
  endtask

  task automatic test_backpressure();
    @(negedge ACLK);
    bus.bready = 1'b0;
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'h11; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge ACLK); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge ACLK);
    vectors++;
    if (bus.bvalid !== 1'b1) begin miscompares++; $display("FAIL bp_bvalid got %b want 1", bus.bvalid); end
    bus.wdata = 32'h22; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      vectors++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100) begin
        miscompares++; $display("FAIL bp_stall_%0d got %b want 100", i, {bus.bvalid, bus.awready, bus.wready});
      end
    end
    vectors++;
    if (addr_o !== 32'h11) begin miscompares++; $display("FAIL bp_addr_hold got %h want 11", addr_o); end
    bus.bready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge ACLK);
    vectors++;
    if (bus.bvalid !== 1'b1 || addr_o !== 32'h22) begin
      miscompares++; $display("FAIL bp_second_write got %b/%h want 1/22", bus.bvalid, addr_o);
    end
    @(negedge ACLK);
    bus.bready = 1'b0;
    vectors++;
    if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL bp_bvalid_clear got %b want 0", bus.bvalid); end
  endtask

  task automatic test_read_mux();
    logic [5:0]  offs [6] = '{6'h10, 6'h14, 6'h18, 6'h20, 6'h3C, 6'h07};
    logic [31:0] exps [6] = '{32'h2, 32'h89ABCDEF, 32'h01234567, 32'h0, 32'h0, 32'h0000A5A5};
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [63:0] dp;
    int cp, dpn;
    status_i = 32'h2; dout_i = 64'h01234567_89ABCDEF;
    axi_write(6'h04, 32'h0000A5A5, 4'hF, resp, cp, dpn, dp);
    for (int i = 0; i < 6; i++) begin
      axi_read(offs[i], rd, resp);
      vectors++;
      if (rd !== exps[i] || resp !== 2'b00) begin
        miscompares++; $display("FAIL rmux_%h got %h/%b want %h/00", offs[i], rd, resp, exps[i]);
      end
    end
    // Latency, sample point and hold-until-handshake.
    @(negedge ACLK);
    bus.araddr = 6'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge ACLK); bus.arvalid = 1'b0;
    vectors++;
    if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_early got %b want 0", bus.rvalid); end
    status_i = 32'h5;
    @(negedge ACLK);
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h5 || bus.arready !== 1'b0) begin
      miscompares++; $display("FAIL rd_latency got %b/%h/%b want 1/5/0", bus.rvalid, bus.rdata, bus.arready);
    end
    status_i = 32'h7;
    @(negedge ACLK);
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h5) begin
      miscompares++; $display("FAIL rdata_hold got %b/%h want 1/5", bus.rvalid, bus.rdata);
    end
    bus.rready = 1'b1;
    @(negedge ACLK);
    bus.rready = 1'b0;
    vectors++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      miscompares++; $display("FAIL r_release got %b/%b want 0/1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge ACLK);
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'h5A5A0000; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 6'h04; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge ACLK);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge ACLK);
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0000A5A5 || bus.bvalid !== 1'b1) begin
      miscompares++; $display("FAIL same_edge_rw got %b/%h/%b want 1/0000a5a5/1", bus.rvalid, bus.rdata, bus.bvalid);
    end
    vectors++;
    if (addr_o !== 32'h5A5A0000) begin miscompares++; $display("FAIL same_edge_addr got %h want 5a5a0000", addr_o); end
    @(negedge ACLK);
    bus.bready = 1'b0; bus.rready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int nr = 0, nb = 0;
    @(negedge ACLK);
    bus.araddr = 6'h14; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.wdata = 32'hFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge ACLK); bus.arvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge ACLK);
    vectors++;
    if (bus.rvalid !== 1'b1) begin miscompares++; $display("FAIL pend_rvalid got %b want 1", bus.rvalid); end
    #2 ARESETN = 1'b0;
    #1;
    vectors++;
    if ({bus.rvalid, bus.arready, bus.awready, bus.wready} !== 4'b0000 || ctrl_o !== 32'h0 || addr_o !== 32'h0) begin
      miscompares++; $display("FAIL mid_reset got %b/%h/%h want 0000/0/0", {bus.rvalid, bus.arready, bus.awready, bus.wready}, ctrl_o, addr_o);
    end
    @(negedge ACLK); @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      nr += int'(bus.rvalid); nb += int'(bus.bvalid);
    end
    vectors++;
    if (nr != 0 || nb != 0) begin miscompares++; $display("FAIL after_reset_valids got r=%0d b=%0d want 0/0", nr, nb); end
  endtask

  initial begin
    test_reset();
    test_reg_rw();
    test_w_before_aw();
    test_strobe();
    test_backpressure();
    test_read_mux();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
